fsm_result_collector: RTL

- Downstream consumer of the 2-bit symbol FSM: captures each result pulse (out_valid/out), buffers it with a sequence tag in a small FIFO, and keeps per-value hit counters.
- Presents buffered results to the host-side reader through a valid/ready interface.
- Flags protocol violations: illegal result code 2'b11 and FIFO overflow.
- Samples on posedge clk; the upstream drives on negedge, so its inputs are stable at every posedge.

---
 rtl/fsm_pkg.sv | 13 +
 rtl/fsm_result_collector_if.sv | 28 ++
 rtl/fsm_result_collector_fifo.sv | 59 +++++
 rtl/fsm_result_collector.sv | 114 +++++++++++
 4 files changed

// File: rtl/fsm_pkg.sv
// Shared definitions for the 2-bit symbol FSM and its downstream consumers.
// Holds the result code encodings and the upstream frame length.
package fsm_pkg;

    localparam int unsigned SYM_W     = 2;
    localparam int unsigned MAX_FRAME = 20;

    localparam logic [SYM_W-1:0] RES_ZERO = 2'b00;
    localparam logic [SYM_W-1:0] RES_ONE  = 2'b01;
    localparam logic [SYM_W-1:0] RES_TWO  = 2'b10;
    localparam logic [SYM_W-1:0] SYM_TERM = 2'b11;

endpackage

// File: rtl/fsm_result_collector_if.sv
// Result/reader handshake bundle for fsm_result_collector.
//   res_valid/res_data : result strobe and value from the symbol FSM
//   rd_ready           : reader accepts the head entry
//   rd_valid/rd_data/rd_seq : head entry presented to the reader
// master = FSM + reader side, slave = collector.
interface fsm_result_collector_if #(
    parameter int unsigned SEQ_W = 4
);
    import fsm_pkg::*;

    logic             res_valid;
    logic [SYM_W-1:0] res_data;
    logic             rd_ready;
    logic             rd_valid;
    logic [SYM_W-1:0] rd_data;
    logic [SEQ_W-1:0] rd_seq;

    modport master (
        output res_valid, res_data, rd_ready,
        input  rd_valid, rd_data, rd_seq
    );

    modport slave (
        input  res_valid, res_data, rd_ready,
        output rd_valid, rd_data, rd_seq
    );

endinterface

// File: rtl/fsm_result_collector_fifo.sv
// result_fifo: small synchronous FIFO with combinational head read.
//   clk, rst : clock and synchronous active-high reset (discards contents)
//   push/din : write request and data; accepted when not full or when
//              a pop happens on the same edge
//   pop      : remove head; ignored while empty
//   dout     : head entry (meaningful only while !empty)
//   empty/full : derived from the registered occupancy
module result_fifo #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;

    logic w_do_push;
    logic w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == (AW+1)'(DEPTH));
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign dout      = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            // Pointers are exactly AW bits, so they wrap on their own.
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: stale data is never visible past the pointers.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= din;
    end

endmodule

// File: rtl/fsm_result_collector.sv
// fsm_result_collector: captures result pulses from the symbol FSM, tags each
// with a sequence number, buffers them for a reader and keeps a histogram.
//   clk, rst  : clock (posedge) and synchronous active-high reset
//   bus       : slave side of fsm_result_collector_if (result in, reader out)
//   clr_stats : clears histogram and sticky flags
//   fifo_full : FIFO holds DEPTH entries
//   overflow  : sticky, a legal result was dropped because the FIFO was full
//   illegal   : sticky, result code SYM_TERM was received
//   cnt0..2   : saturating per-value result counts
module fsm_result_collector
    import fsm_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned SEQ_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    fsm_result_collector_if.slave  bus,
    input  logic                   clr_stats,
    output logic                   fifo_full,
    output logic                   overflow,
    output logic                   illegal,
    output logic [CNT_W-1:0]       cnt0,
    output logic [CNT_W-1:0]       cnt1,
    output logic [CNT_W-1:0]       cnt2
);
    localparam int unsigned   ENT_W   = SEQ_W + SYM_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             r_res_valid_q;
    logic [SEQ_W-1:0] r_seq;
    logic [CNT_W-1:0] r_cnt0, r_cnt1, r_cnt2;
    logic             r_overflow;
    logic             r_illegal;

    logic             w_capture;
    logic             w_legal_cap;
    logic             w_illegal_cap;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic             w_empty;
    logic             w_full;
    logic [ENT_W-1:0] w_din;
    logic [ENT_W-1:0] w_dout;

    // Rising edge of the strobe: a long high counts once.
    assign w_capture     = bus.res_valid && !r_res_valid_q;
    assign w_illegal_cap = w_capture && (bus.res_data == SYM_TERM);
    assign w_legal_cap   = w_capture && (bus.res_data != SYM_TERM);
    assign w_pop         = !w_empty && bus.rd_ready;
    // A full FIFO still takes the entry if the head leaves on the same edge.
    assign w_push        = w_legal_cap && (!w_full || w_pop);
    assign w_drop        = w_legal_cap && w_full && !w_pop;
    assign w_din         = {r_seq, bus.res_data};

    result_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_din),
        .dout  (w_dout),
        .empty (w_empty),
        .full  (w_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_valid_q <= 1'b0;
            r_seq         <= '0;
        end else begin
            r_res_valid_q <= bus.res_valid;
            if (w_push) r_seq <= r_seq + 1'b1;
        end
    end

    // Clear takes priority over any same-edge increment or flag set.
    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            r_cnt0     <= '0;
            r_cnt1     <= '0;
            r_cnt2     <= '0;
            r_overflow <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            if (w_legal_cap) begin
                unique case (bus.res_data)
                    RES_ZERO: if (r_cnt0 != CNT_MAX) r_cnt0 <= r_cnt0 + 1'b1;
                    RES_ONE:  if (r_cnt1 != CNT_MAX) r_cnt1 <= r_cnt1 + 1'b1;
                    RES_TWO:  if (r_cnt2 != CNT_MAX) r_cnt2 <= r_cnt2 + 1'b1;
                    default:  ;
                endcase
            end
            if (w_drop)        r_overflow <= 1'b1;
            if (w_illegal_cap) r_illegal  <= 1'b1;
        end
    end

    assign bus.rd_valid = !w_empty;
    assign bus.rd_data  = w_empty ? '0 : w_dout[SYM_W-1:0];
    assign bus.rd_seq   = w_empty ? '0 : w_dout[SYM_W +: SEQ_W];
    assign fifo_full    = w_full;
    assign overflow     = r_overflow;
    assign illegal      = r_illegal;
    assign cnt0         = r_cnt0;
    assign cnt1         = r_cnt1;
    assign cnt2         = r_cnt2;

endmodule
